// File: rtl/feature_map_writer_pkg.sv
// Shared definitions for the feature-map writer: the state encoding and a
// helper that returns the number of pixels in one output frame.
package feature_map_writer_pkg;

  localparam logic [1:0] FMW_IDLE    = 2'd0;
  localparam logic [1:0] FMW_CAPTURE = 2'd1;
  localparam logic [1:0] FMW_DONE    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = FMW_IDLE,
    ST_CAPTURE = FMW_CAPTURE,
    ST_DONE    = FMW_DONE
  } fmw_state_t;

  function automatic int frame_size(input int out_width, input int out_height);
    return out_width * out_height;
  endfunction

endpackage

// File: rtl/feature_map_ram.sv
// Simple dual-port synchronous RAM holding one output frame.
// Ports:
//   clk, reset      - clock; synchronous active-high reset (clears rd_data only)
//   clk_en          - global enable; gates both the write and the read register
//   wr_en/wr_addr/wr_data - write port
//   rd_addr/rd_data - read port, one-cycle latency, returns old data when the
//                     same address is written in the same cycle
module feature_map_ram
  import feature_map_writer_pkg::*;
#(
  parameter int DATA_WIDTH = 80,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Contents are deliberately never reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (clk_en && wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (clk_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/feature_map_writer.sv
// Captures the convolutional layer's valid output pixels into a frame buffer
// in raster order and offers a registered read port.
// Optional build macro: FEATURE_MAP_WRITER_RELU_EN - clamps negative channels
// to zero before they are stored.
// Ports:
//   clk, reset   - clock; synchronous active-high reset (overrides clk_en)
//   clk_en       - global clock enable, freezes all state when low
//   start        - arm a new frame (honoured in IDLE and DONE)
//   valid        - data_in carries a pixel this cycle
//   data_in      - packed pixel, channel 0 in the MSBs
//   rd_addr      - raster read address row*OUT_WIDTH+col
//   rd_data      - registered read data
//   busy         - capturing a frame
//   frame_done   - frame complete
//   overflow     - sticky, a pixel arrived after the frame was complete
//   pixel_count  - pixels written in the current frame
//
// state   | meaning
// IDLE    | after reset, waiting for start; pixels ignored
// CAPTURE | writing valid pixels in raster order
// DONE    | frame complete; extra pixels flag overflow, start re-arms
module feature_map_writer
  import feature_map_writer_pkg::*;
#(
  parameter int Q_WIDTH    = 16,
  parameter int Q_CHANNELS = 5,
  parameter int OUT_WIDTH  = 60,
  parameter int OUT_HEIGHT = 28,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic                          start,
  input  logic                          valid,
  input  logic [Q_CHANNELS*Q_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0]         rd_addr,
  output logic [Q_CHANNELS*Q_WIDTH-1:0] rd_data,
  output logic                          busy,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [ADDR_WIDTH:0]           pixel_count
);

  localparam int DW = Q_CHANNELS * Q_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] COL_LAST   = ADDR_WIDTH'(OUT_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] FRAME_LAST =
    ADDR_WIDTH'(frame_size(OUT_WIDTH, OUT_HEIGHT) - 1);

  fmw_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] row;
  logic [ADDR_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DW-1:0]         wr_data;
  logic                  wr_en;
  logic                  clear_cnt;
  logic                  set_ovf;
  logic                  last_pixel;

  // The running address equals row*OUT_WIDTH+col, so it alone identifies the
  // final pixel of the frame.
  assign last_pixel = (wr_addr == FRAME_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    clear_cnt  = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_CAPTURE;
          clear_cnt  = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (valid) begin
          wr_en = 1'b1;
          if (last_pixel) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // A start in the same cycle as a stray pixel re-arms and drops it.
        if (start) begin
          state_next = ST_CAPTURE;
          clear_cnt  = 1'b1;
        end else if (valid) begin
          set_ovf = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row         <= '0;
      col         <= '0;
      wr_addr     <= '0;
      pixel_count <= '0;
      overflow    <= 1'b0;
    end else if (clk_en) begin
      if (clear_cnt) begin
        row         <= '0;
        col         <= '0;
        wr_addr     <= '0;
        pixel_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_addr     <= wr_addr + 1'b1;
          pixel_count <= pixel_count + 1'b1;
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        if (set_ovf) begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef FEATURE_MAP_WRITER_RELU_EN
  always_comb begin
    wr_data = data_in;
    for (int c = 0; c < Q_CHANNELS; c++) begin
      if (data_in[c*Q_WIDTH + Q_WIDTH - 1]) begin
        wr_data[c*Q_WIDTH +: Q_WIDTH] = '0;
      end
    end
  end
`else
  assign wr_data = data_in;
`endif

  assign busy       = (state == ST_CAPTURE);
  assign frame_done = (state == ST_DONE);

  feature_map_ram #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: doc/feature_map_writer.md
Name: feature_map_writer

Overview:
- Receiving end of the convolutional layer's output stream. Captures each `valid` output pixel (all Q_CHANNELS packed) into an on-chip frame buffer in raster order, tracking row and column.
- Signals frame completion and exposes a synchronous read port for the next layer or host readback.
- Sits directly after convolutional_layer. Shares its clk/clk_en domain.

Parameters:
- Q_WIDTH, 16, bits per output channel.
- Q_CHANNELS, 5, channels packed per pixel; channel 0 in the MSBs.
- OUT_WIDTH, 60, output pixels per row (IMAGE_SIZE-FILTER_SIZE+1).
- OUT_HEIGHT, 28, output rows per frame.
- ADDR_WIDTH, 11, frame-buffer address width; must satisfy 2^ADDR_WIDTH >= OUT_WIDTH*OUT_HEIGHT.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clk_en  in  1  global clock enable; when low, all state holds, including the read pipeline.
- start  in  1  arm capture of a new frame; sampled in IDLE and DONE only.
- valid  in  1  data_in holds a valid pixel this cycle.
- data_in  in  Q_CHANNELS*Q_WIDTH  packed output pixel.
- rd_addr  in  ADDR_WIDTH  read address (raster index row*OUT_WIDTH+col).
- rd_data  out  Q_CHANNELS*Q_WIDTH  registered read data.
- busy  out  1  high in CAPTURE.
- frame_done  out  1  high in DONE.
- overflow  out  1  sticky; a valid pixel arrived in DONE.
- pixel_count  out  ADDR_WIDTH+1  pixels written in the current frame.

Behaviour:
- Reset (synchronous, active-high, takes precedence over clk_en):
  - state=IDLE.
  - busy=0, frame_done=0, overflow=0, pixel_count=0, rd_data=0.
  - Internal row=0, col=0.
  - Memory contents are not cleared.
- All updates are qualified by clk_en=1 (except reset).
- State machine:
  - IDLE: start=1 -> CAPTURE; pixel_count, row and col cleared. valid in IDLE is ignored; no write, no overflow.
  - CAPTURE: each cycle with valid=1 writes data_in to mem[row*OUT_WIDTH+col].
    - The address is kept as a running counter, not a multiply.
    - col increments; at col=OUT_WIDTH-1, col wraps to 0 and row increments.
    - pixel_count increments.
    - The write of the last pixel (row=OUT_HEIGHT-1, col=OUT_WIDTH-1) moves to DONE on the same edge.
    - start is ignored in CAPTURE.
  - DONE: frame_done=1.
    - valid=1 sets overflow; no write; counters hold.
    - start=1 -> CAPTURE, counters cleared, overflow cleared. start and valid in the same cycle: the start wins and that pixel is dropped.
- Write latency: a pixel presented on edge N is readable via rd_addr on edge N+1, with rd_data valid after edge N+2.
- Read port:
  - Synchronous, 1-cycle latency: rd_data <= mem[rd_addr] when clk_en=1.
  - Available in every state.
  - Read and write to the same address in the same cycle returns the old contents.
  - rd_addr >= OUT_WIDTH*OUT_HEIGHT returns undefined data; the bench must not check it.
- Data is stored unmodified: no width change, and channel order is preserved.
- Reset mid-CAPTURE: returns to IDLE. Partially written memory is retained; pixel_count=0.

Optional Feature:
- Macro: FEATURE_MAP_WRITER_RELU_EN.
- Defined: each Q_WIDTH channel is treated as two's complement before the write; a negative channel (MSB=1) is stored as 0, and a non-negative channel is stored unchanged. This is a purely combinational stage; write latency is unchanged.
- Undefined: data is stored exactly as received.

Decomposition:
- Shared package/definitions include:
  - State encoding localparams FMW_IDLE=2'd0, FMW_CAPTURE=2'd1, FMW_DONE=2'd2.
  - Helper function computing the frame size OUT_WIDTH*OUT_HEIGHT.
- One sub-module: feature_map_ram, a simple dual-port synchronous RAM.
  - One write port, one read port, clk_en-gated, read-old-on-collision.
  - Parameters DATA_WIDTH, ADDR_WIDTH.
- The FSM, counters and ReLU stage stay in feature_map_writer.

Test Plan:
- Full frame: OUT_WIDTH=4, OUT_HEIGHT=3, Q_CHANNELS=2, Q_WIDTH=8.
  - Stimulus: start, then 12 valid pixels {k,k+8'h40} for k=0..11, valid every cycle.
  - Response: frame_done rises on the edge after pixel 11, pixel_count=12, busy=0. Reading addr 0..11 returns {k,k+8'h40}.
- Gapped valid / clk_en:
  - Stimulus: same frame with valid on alternate cycles and clk_en low for 3 cycles mid-row.
  - Response: identical memory contents; pixel_count advances only on valid&&clk_en.
- Overflow and ignore:
  - Stimulus: valid in IDLE writes nothing (addr 0 keeps its prior value). After DONE, one extra valid pixel is presented.
  - Response: overflow=1, addr 11 unchanged. A following start clears overflow and sets busy=1.
- Reset mid-frame:
  - Stimulus: reset asserted after 5 pixels.
  - Response: state IDLE, pixel_count=0. A restarted frame overwrites addr 0..4 correctly.
- Read/write collision:
  - Stimulus: rd_addr=3 on the same cycle pixel 3 (value 8'hAA) is written, previous contents 8'h11.
  - Response: rd_data=8'h11 next cycle; a re-read gives 8'hAA.
- With FEATURE_MAP_WRITER_RELU_EN defined:
  - Stimulus: channel value 8'hF0.
  - Response: stored as 8'h00; 8'h7F is stored as 8'h7F.
